proc_mngr_port: RTL and testbench

- Processor-side endpoint of the manager test channel: the responder to the bench manager.
- Turns pipeline manager-CSR accesses into val/rdy traffic. A read (csrr mngr2proc) pops an inbound message; a write (csrw proc2mngr) pushes an outbound message.
- Sits between the core's CSR stage and the mngr2proc/proc2mngr pins.
- Buffers both directions with small FIFOs and stalls the pipeline when a buffer is empty (read) or full (write).

---
 rtl/proc_mngr_port.sv | 163 ++++++++++++++++
 tb/tb_proc_mngr_port.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_mngr_port.sv
// Processor-side manager test-channel endpoint: CSR reads pop mngr2proc, CSR writes push proc2mngr.
// Both directions are buffered in small FIFOs; the pipeline stalls on empty (read) or full (write).
module proc_mngr_port #(
    parameter int W         = 32,
    parameter int IN_DEPTH  = 2,
    parameter int OUT_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         csr_val,
    input  logic         csr_wr,
    input  logic [W-1:0] csr_wdata,
    output logic         csr_stall,
    output logic [W-1:0] csr_rdata,

    input  logic         mngr2proc_val,
    output logic         mngr2proc_rdy,
    input  logic [W-1:0] mngr2proc_msg,

    output logic         proc2mngr_val,
    input  logic         proc2mngr_rdy,
    output logic [W-1:0] proc2mngr_msg,

    output logic [15:0]  recv_cnt,
    output logic [15:0]  sent_cnt
);

    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int IN_CW  = IN_AW + 1;
    localparam int OUT_CW = OUT_AW + 1;

    logic [W-1:0]      in_mem_q  [IN_DEPTH];
    logic [W-1:0]      in_mem_d  [IN_DEPTH];
    logic [IN_AW-1:0]  in_wptr_q, in_wptr_d;
    logic [IN_AW-1:0]  in_rptr_q, in_rptr_d;
    logic [IN_AW:0]    in_cnt_q,  in_cnt_d;

    logic [W-1:0]      out_mem_q [OUT_DEPTH];
    logic [W-1:0]      out_mem_d [OUT_DEPTH];
    logic [OUT_AW-1:0] out_wptr_q, out_wptr_d;
    logic [OUT_AW-1:0] out_rptr_q, out_rptr_d;
    logic [OUT_AW:0]   out_cnt_q,  out_cnt_d;

    logic [15:0]       recv_cnt_q, recv_cnt_d;
    logic [15:0]       sent_cnt_q, sent_cnt_d;

    logic in_empty, in_full, out_empty, out_full;
    logic in_push, in_pop, out_push, out_pop;

    // Depth is a power of two, so the count MSB alone marks full.
    always_comb begin
        in_empty  = (in_cnt_q == '0);
        in_full   = in_cnt_q[IN_AW];
        out_empty = (out_cnt_q == '0);
        out_full  = out_cnt_q[OUT_AW];
    end

    always_comb begin
        mngr2proc_rdy = !rst && !in_full;
        csr_stall     = !rst && csr_val && (csr_wr ? out_full : in_empty);
        csr_rdata     = in_empty ? '0 : in_mem_q[in_rptr_q];
        proc2mngr_val = !out_empty;
        proc2mngr_msg = out_empty ? '0 : out_mem_q[out_rptr_q];
        recv_cnt      = recv_cnt_q;
        sent_cnt      = sent_cnt_q;
    end

    // A full outbound FIFO stalls writes even when the manager pops this cycle.
    always_comb begin
        in_push  = mngr2proc_val && mngr2proc_rdy;
        in_pop   = csr_val && !csr_wr && !in_empty;
        out_push = csr_val && csr_wr && !out_full;
        out_pop  = proc2mngr_val && proc2mngr_rdy;
    end

    always_comb begin
        in_mem_d  = in_mem_q;
        in_wptr_d = in_wptr_q;
        in_rptr_d = in_rptr_q;
        in_cnt_d  = in_cnt_q;
        if (in_push) begin
            in_mem_d[in_wptr_q] = mngr2proc_msg;
            in_wptr_d           = in_wptr_q + IN_AW'(1);
        end
        if (in_pop) begin
            in_rptr_d = in_rptr_q + IN_AW'(1);
        end
        case ({in_push, in_pop})
            2'b10:   in_cnt_d = in_cnt_q + IN_CW'(1);
            2'b01:   in_cnt_d = in_cnt_q - IN_CW'(1);
            default: in_cnt_d = in_cnt_q;
        endcase
    end

    always_comb begin
        out_mem_d  = out_mem_q;
        out_wptr_d = out_wptr_q;
        out_rptr_d = out_rptr_q;
        out_cnt_d  = out_cnt_q;
        if (out_push) begin
            out_mem_d[out_wptr_q] = csr_wdata;
            out_wptr_d            = out_wptr_q + OUT_AW'(1);
        end
        if (out_pop) begin
            out_rptr_d = out_rptr_q + OUT_AW'(1);
        end
        case ({out_push, out_pop})
            2'b10:   out_cnt_d = out_cnt_q + OUT_CW'(1);
            2'b01:   out_cnt_d = out_cnt_q - OUT_CW'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_comb begin
        recv_cnt_d = in_push  ? recv_cnt_q + 16'd1 : recv_cnt_q;
        sent_cnt_d = out_pop  ? sent_cnt_q + 16'd1 : sent_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IN_DEPTH; i++) begin
                in_mem_q[i] <= '0;
            end
            in_wptr_q <= '0;
            in_rptr_q <= '0;
            in_cnt_q  <= '0;
        end else begin
            in_mem_q  <= in_mem_d;
            in_wptr_q <= in_wptr_d;
            in_rptr_q <= in_rptr_d;
            in_cnt_q  <= in_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                out_mem_q[i] <= '0;
            end
            out_wptr_q <= '0;
            out_rptr_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            out_mem_q  <= out_mem_d;
            out_wptr_q <= out_wptr_d;
            out_rptr_q <= out_rptr_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            recv_cnt_q <= '0;
            sent_cnt_q <= '0;
        end else begin
            recv_cnt_q <= recv_cnt_d;
            sent_cnt_q <= sent_cnt_d;
        end
    end

endmodule

// File: tb/tb_proc_mngr_port.sv
// Bench for proc_mngr_port: queue-based model checked every cycle, directed scenarios, then random traffic.
module tb_proc_mngr_port;
    localparam int W  = 32;
    localparam int ID = 2;
    localparam int OD = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         csr_val = 1'b0, csr_wr = 1'b0;
    logic [W-1:0] csr_wdata = '0;
    logic         csr_stall;
    logic [W-1:0] csr_rdata;
    logic         mngr2proc_val = 1'b0;
    logic         mngr2proc_rdy;
    logic [W-1:0] mngr2proc_msg = '0;
    logic         proc2mngr_val;
    logic         proc2mngr_rdy = 1'b0;
    logic [W-1:0] proc2mngr_msg;
    logic [15:0]  recv_cnt, sent_cnt;

    proc_mngr_port #(.W(W), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
        .clk(clk), .rst(rst),
        .csr_val(csr_val), .csr_wr(csr_wr), .csr_wdata(csr_wdata),
        .csr_stall(csr_stall), .csr_rdata(csr_rdata),
        .mngr2proc_val(mngr2proc_val), .mngr2proc_rdy(mngr2proc_rdy), .mngr2proc_msg(mngr2proc_msg),
        .proc2mngr_val(proc2mngr_val), .proc2mngr_rdy(proc2mngr_rdy), .proc2mngr_msg(proc2mngr_msg),
        .recv_cnt(recv_cnt), .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] inq[$];
    logic [W-1:0] outq[$];
    logic [15:0]  m_recv = '0;
    logic [15:0]  m_sent = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        inq.delete();
        outq.delete();
        m_recv = '0;
        m_sent = '0;
    endtask

    // Expected outputs follow directly from queue occupancy and the current inputs.
    task automatic model_check();
        logic         e_rdy, e_stall, e_pval;
        logic [W-1:0] e_rdata, e_pmsg;
        e_rdy   = !rst && (inq.size() < ID);
        e_stall = !rst && csr_val && (csr_wr ? (outq.size() == OD) : (inq.size() == 0));
        e_rdata = (inq.size() != 0) ? inq[0] : '0;
        e_pval  = (outq.size() != 0);
        e_pmsg  = (outq.size() != 0) ? outq[0] : '0;
        chk("m_rdy",     32'(mngr2proc_rdy), 32'(e_rdy));
        chk("csr_stall", 32'(csr_stall),     32'(e_stall));
        chk("csr_rdata", csr_rdata,          e_rdata);
        chk("p_val",     32'(proc2mngr_val), 32'(e_pval));
        chk("p_msg",     proc2mngr_msg,      e_pmsg);
        chk("recv_cnt",  32'(recv_cnt),      32'(m_recv));
        chk("sent_cnt",  32'(sent_cnt),      32'(m_sent));
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_update();
        bit in_push, in_pop, out_push, out_pop;
        if (rst) return;
        in_push  = mngr2proc_val && (inq.size() < ID);
        in_pop   = csr_val && !csr_wr && (inq.size() != 0);
        out_push = csr_val && csr_wr && (outq.size() < OD);
        out_pop  = (outq.size() != 0) && proc2mngr_rdy;
        if (in_pop)   void'(inq.pop_front());
        if (in_push)  inq.push_back(mngr2proc_msg);
        if (out_pop)  void'(outq.pop_front());
        if (out_push) outq.push_back(csr_wdata);
        if (in_push)  m_recv = m_recv + 16'd1;
        if (out_pop)  m_sent = m_sent + 16'd1;
    endtask

    task automatic step(input logic cv, input logic cw, input logic [W-1:0] wd,
                        input logic mv, input logic [W-1:0] mm, input logic pr);
        @(negedge clk);
        csr_val       = cv;
        csr_wr        = cw;
        csr_wdata     = wd;
        mngr2proc_val = mv;
        mngr2proc_msg = mm;
        proc2mngr_rdy = pr;
        #1;
        model_check();
        model_update();
    endtask

    task automatic idle_inputs();
        csr_val       = 1'b0;
        csr_wr        = 1'b0;
        csr_wdata     = '0;
        mngr2proc_val = 1'b0;
        mngr2proc_msg = '0;
        proc2mngr_rdy = 1'b0;
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic async_reset(input int hold);
        @(negedge clk);
        #2;
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rst_p_val", 32'(proc2mngr_val), 32'd0);
        chk("rst_p_msg", proc2mngr_msg, 32'd0);
        chk("rst_recv",  32'(recv_cnt), 32'd0);
        chk("rst_sent",  32'(sent_cnt), 32'd0);
        chk("rst_m_rdy", 32'(mngr2proc_rdy), 32'd0);
        model_reset();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            model_check();
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic         r_cv, r_cw, r_mv, r_pr;
    logic [W-1:0] r_wd, r_mm;

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        #1;
        model_check();
        chk("reset_rdy", 32'(mngr2proc_rdy), 32'd0);
        chk("reset_stall", 32'(csr_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic read: read held from the cycle the message arrives
        step(1, 0, '0, 1, 32'h21, 0);
        chk("rd_first_stall", 32'(csr_stall), 32'd1);
        step(1, 0, '0, 0, '0, 0);
        chk("rd_stall_done", 32'(csr_stall), 32'd0);
        chk("rd_data", csr_rdata, 32'h21);
        step(0, 0, '0, 0, '0, 0);
        chk("rd_recv_cnt", 32'(recv_cnt), 32'd1);

        // Basic write
        step(1, 1, 32'h4B, 0, '0, 1);
        chk("wr_stall", 32'(csr_stall), 32'd0);
        chk("wr_pval_n", 32'(proc2mngr_val), 32'd0);
        step(0, 0, '0, 0, '0, 1);
        chk("wr_pval_n1", 32'(proc2mngr_val), 32'd1);
        chk("wr_pmsg", proc2mngr_msg, 32'h4B);
        step(0, 0, '0, 0, '0, 1);
        chk("wr_pval_n2", 32'(proc2mngr_val), 32'd0);
        chk("wr_sent_cnt", 32'(sent_cnt), 32'd1);

        // Outbound backpressure
        step(1, 1, 32'h1, 0, '0, 0);
        step(1, 1, 32'h2, 0, '0, 0);
        step(1, 1, 32'h3, 0, '0, 0);
        chk("bp_third_stall", 32'(csr_stall), 32'd1);
        step(1, 1, 32'h3, 0, '0, 1);
        chk("bp_full_pop_stall", 32'(csr_stall), 32'd1);
        chk("bp_msg1", proc2mngr_msg, 32'h1);
        step(1, 1, 32'h3, 0, '0, 1);
        chk("bp_third_done", 32'(csr_stall), 32'd0);
        chk("bp_msg2", proc2mngr_msg, 32'h2);
        step(0, 0, '0, 0, '0, 1);
        chk("bp_msg3", proc2mngr_msg, 32'h3);
        step(0, 0, '0, 0, '0, 1);
        chk("bp_drained", 32'(proc2mngr_val), 32'd0);

        // Inbound full
        step(0, 0, '0, 1, 32'hA, 0);
        chk("if_rdy0", 32'(mngr2proc_rdy), 32'd1);
        step(0, 0, '0, 1, 32'hB, 0);
        step(0, 0, '0, 1, 32'hC, 0);
        chk("if_full_rdy", 32'(mngr2proc_rdy), 32'd0);
        step(1, 0, '0, 1, 32'hC, 0);
        chk("if_rd_a", csr_rdata, 32'hA);
        chk("if_rdy_still0", 32'(mngr2proc_rdy), 32'd0);
        step(0, 0, '0, 1, 32'hC, 0);
        chk("if_rdy_rise", 32'(mngr2proc_rdy), 32'd1);
        step(1, 0, '0, 0, '0, 0);
        chk("if_rd_b", csr_rdata, 32'hB);
        step(1, 0, '0, 0, '0, 0);
        chk("if_rd_c", csr_rdata, 32'hC);
        step(0, 0, '0, 0, '0, 0);
        chk("if_recv_cnt", 32'(recv_cnt), 32'd4);

        // Simultaneous push and read with one entry buffered
        step(0, 0, '0, 1, 32'h7, 0);
        step(1, 0, '0, 1, 32'h5, 0);
        chk("sim_old_head", csr_rdata, 32'h7);
        step(0, 0, '0, 0, '0, 0);
        chk("sim_one_left_rdy", 32'(mngr2proc_rdy), 32'd1);
        step(1, 0, '0, 0, '0, 0);
        chk("sim_new_head", csr_rdata, 32'h5);
        step(1, 0, '0, 0, '0, 0);
        chk("sim_empty_stall", 32'(csr_stall), 32'd1);

        // Reset mid-operation with two outbound entries pending
        step(1, 1, 32'h11, 0, '0, 0);
        step(1, 1, 32'h22, 0, '0, 0);
        step(0, 0, '0, 0, '0, 0);
        chk("mid_pending", proc2mngr_msg, 32'h11);
        async_reset(2);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, '0, 0, '0, 1);
            chk("post_rst_no_stale", 32'(proc2mngr_val), 32'd0);
        end

        // Random traffic; a stalled access is held stable as the pipeline would.
        r_cv = 0; r_cw = 0; r_wd = '0;
        for (int i = 0; i < 4000; i++) begin
            if (!(csr_val && csr_stall)) begin
                r_cv = ($urandom_range(0, 99) < 60);
                r_cw = $urandom_range(0, 1) != 0;
                r_wd = $urandom;
            end
            r_mv = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 70 : 30));
            r_mm = $urandom;
            r_pr = ($urandom_range(0, 99) < ((i / 700) % 2 == 0 ? 30 : 80));
            step(r_cv, r_cw, r_wd, r_mv, r_mm, r_pr);
            if (i % 1100 == 1099) async_reset($urandom_range(1, 3));
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
